nios2_oci_dct_ctrl: RTL

Sequencer for the OCI direct-compressed-trace (DCT) buffer. It packs 2-bit trace atoms from the CPU trace source into a 30-bit buffer of up to 15 atoms and hands completed or flushed frames to the trace sink over a valid/ready handshake. It also drives the live dct_buffer/dct_count monitor outputs and implements the test_ending/test_has_ended end-of-test drain.

---
 rtl/nios2_oci_dct_pkg.sv | 20 ++
 rtl/nios2_oci_dct_ctrl_if.sv | 29 ++
 rtl/nios2_oci_dct_pack.sv | 38 +++
 rtl/nios2_oci_dct_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants and types for the OCI direct-compressed-trace buffer sequencer.
package nios2_oci_dct_pkg;

  localparam int unsigned ATOM_W    = 2;
  localparam int unsigned NUM_ATOMS = 15;
  localparam int unsigned BUF_W     = ATOM_W * NUM_ATOMS;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    ENDED = 2'd2
  } dct_state_t;

  typedef struct packed {
    logic [BUF_W-1:0] data;
    logic [CNT_W-1:0] count;
  } dct_frame_t;

endpackage

// File: rtl/nios2_oci_dct_ctrl_if.sv
// Trace source / trace sink / monitor signal bundle for the DCT sequencer.
interface nios2_oci_dct_ctrl_if;
  import nios2_oci_dct_pkg::*;

  logic              atom_valid;
  logic [ATOM_W-1:0] atom_data;
  logic              atom_ready;
  logic              flush_req;
  logic              test_ending;
  logic              frame_valid;
  logic [BUF_W-1:0]  frame_data;
  logic [CNT_W-1:0]  frame_count;
  logic              frame_ready;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_has_ended;

  modport master (
    output atom_valid, atom_data, flush_req, test_ending, frame_ready,
    input  atom_ready, frame_valid, frame_data, frame_count,
           dct_buffer, dct_count, test_has_ended
  );

  modport slave (
    input  atom_valid, atom_data, flush_req, test_ending, frame_ready,
    output atom_ready, frame_valid, frame_data, frame_count,
           dct_buffer, dct_count, test_has_ended
  );
endinterface

// File: rtl/nios2_oci_dct_pack.sv
// Accumulation buffer: inserts one atom at the current count, clears on request.
module nios2_oci_dct_pack
  import nios2_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ins_en,
  input  logic [ATOM_W-1:0] ins_data,
  input  logic              clr,
  output logic [BUF_W-1:0]  buffer_q,
  output logic [CNT_W-1:0]  cnt_q,
  output logic [BUF_W-1:0]  buffer_nxt,
  output logic [CNT_W-1:0]  cnt_nxt
);

  // buffer_nxt/cnt_nxt include the same-cycle atom so a flushed frame can capture it.
  always_comb begin
    buffer_nxt = buffer_q;
    cnt_nxt    = cnt_q;
    if (ins_en) begin
      for (int unsigned i = 0; i < NUM_ATOMS; i++) begin
        if (cnt_q == CNT_W'(i)) buffer_nxt[i*ATOM_W +: ATOM_W] = ins_data;
      end
      cnt_nxt = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      buffer_q <= '0;
      cnt_q    <= '0;
    end else begin
      buffer_q <= buffer_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_ctrl.sv
// DCT sequencer: packs trace atoms into frames, hands them to the sink, drains at end of test.
module nios2_oci_dct_ctrl
  import nios2_oci_dct_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  nios2_oci_dct_ctrl_if.slave  bus
);

  dct_state_t       state_q, state_d;
  dct_frame_t       frame_q, frame_d;
  logic             ending_pending_q;
  logic             accept;
  logic             emit;
  logic [BUF_W-1:0] buffer_q, buffer_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  assign bus.atom_ready     = (state_q == FILL);
  assign bus.frame_valid    = (state_q == EMIT);
  assign bus.test_has_ended = (state_q == ENDED);
  assign bus.frame_data     = frame_q.data;
  assign bus.frame_count    = frame_q.count;
  assign bus.dct_buffer     = buffer_q;
  assign bus.dct_count      = cnt_q;

  assign accept = bus.atom_valid && (state_q == FILL);

  nios2_oci_dct_pack u_pack (
    .clk        (clk),
    .reset      (reset),
    .ins_en     (accept),
    .ins_data   (bus.atom_data),
    .clr        (emit),
    .buffer_q   (buffer_q),
    .cnt_q      (cnt_q),
    .buffer_nxt (buffer_nxt),
    .cnt_nxt    (cnt_nxt)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    emit    = 1'b0;
    unique case (state_q)
      FILL: begin
        // Frame closes on the 15th atom, or on flush/end with anything buffered incl. this cycle's atom.
        if ((accept && cnt_q == CNT_W'(NUM_ATOMS - 1)) ||
            ((bus.flush_req || bus.test_ending) && (cnt_q != '0 || accept))) begin
          emit          = 1'b1;
          frame_d.data  = buffer_nxt;
          frame_d.count = cnt_nxt;
          state_d       = EMIT;
        end else if (bus.test_ending) begin
          state_d = ENDED;
        end
      end
      EMIT: begin
        if (bus.frame_ready) begin
          state_d = (ending_pending_q || bus.test_ending) ? ENDED : FILL;
        end
      end
      ENDED: state_d = ENDED;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= FILL;
      frame_q          <= '0;
      ending_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      if (bus.test_ending && state_q != ENDED) ending_pending_q <= 1'b1;
    end
  end

endmodule
